// File: rtl/fft_symbol_scheduler_if.sv
// Sample, control and status bundle of the FFT symbol scheduler.
// The master side feeds samples and peaks; the slave side is the scheduler itself.
interface fft_symbol_scheduler_if #(
  parameter int unsigned IN_DW       = 32,
  parameter int unsigned NUM_SYMBOLS = 3
);
  localparam int unsigned IdxW = $clog2(NUM_SYMBOLS + 1);

  logic [IN_DW-1:0] s_axis_in_tdata;
  logic             s_axis_in_tvalid;
  logic             peak_detected_i;
  logic             abort_i;
  logic [IN_DW-1:0] m_axis_fft_tdata;
  logic             m_axis_fft_tvalid;
  logic             m_axis_fft_tlast;
  logic [IdxW-1:0]  symbol_idx_o;
  logic             busy_o;
  logic             peak_ignored_o;

  modport master (
    output s_axis_in_tdata, s_axis_in_tvalid, peak_detected_i, abort_i,
    input  m_axis_fft_tdata, m_axis_fft_tvalid, m_axis_fft_tlast, symbol_idx_o, busy_o,
           peak_ignored_o
  );

  modport slave (
    input  s_axis_in_tdata, s_axis_in_tvalid, peak_detected_i, abort_i,
    output m_axis_fft_tdata, m_axis_fft_tvalid, m_axis_fft_tlast, symbol_idx_o, busy_o,
           peak_ignored_o
  );
endinterface

// File: rtl/fft_symbol_scheduler.sv
// Gates a full-rate sample stream into FFT symbols after a PSS peak: skip, then
// alternate symbol / cyclic prefix until NUM_SYMBOLS symbols have been forwarded.
module fft_symbol_scheduler #(
  parameter int unsigned IN_DW       = 32,
  parameter int unsigned FFT_LEN     = 256,
  parameter int unsigned CP_LEN      = 18,
  parameter int unsigned FIRST_SKIP  = 279,
  parameter int unsigned NUM_SYMBOLS = 3
) (
  input logic                  clk_i,
  input logic                  reset_ni,
  fft_symbol_scheduler_if.slave sched
);
  localparam int unsigned MaxLen0 = (FIRST_SKIP > FFT_LEN) ? FIRST_SKIP : FFT_LEN;
  localparam int unsigned MaxLen  = (MaxLen0 > CP_LEN) ? MaxLen0 : CP_LEN;
  localparam int unsigned CntW    = $clog2(MaxLen + 1);
  localparam int unsigned IdxW    = $clog2(NUM_SYMBOLS + 1);

  localparam logic [CntW-1:0] SkipLast = CntW'(FIRST_SKIP - 1);
  localparam logic [CntW-1:0] FftLast  = CntW'(FFT_LEN - 1);
  localparam logic [CntW-1:0] CpLast   = (CP_LEN > 0) ? CntW'(CP_LEN - 1) : '0;
  localparam logic [IdxW-1:0] NumSym   = IdxW'(NUM_SYMBOLS);

  typedef enum logic [1:0] {StIdle, StSkip, StSymbol, StCp} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [IdxW-1:0]  idx_q;
  logic [IdxW-1:0]  out_idx_q;
  logic [IN_DW-1:0] tdata_q;
  logic             tvalid_q;
  logic             tlast_q;
  logic             ignored_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      out_idx_q <= '0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      ignored_q <= 1'b0;
    end else begin
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      ignored_q <= 1'b0;
      if (sched.abort_i) begin
        // Abort wins over a simultaneous peak and drops this cycle's sample.
        state_q <= StIdle;
        cnt_q   <= '0;
        idx_q   <= '0;
      end else begin
        if (sched.peak_detected_i && (state_q != StIdle)) begin
          ignored_q <= 1'b1;
        end
        unique case (state_q)
          StIdle: begin
            if (sched.peak_detected_i) begin
              state_q <= StSkip;
              cnt_q   <= '0;
              idx_q   <= '0;
            end
          end
          StSkip: begin
            if (sched.s_axis_in_tvalid) begin
              if (cnt_q == SkipLast) begin
                state_q <= StSymbol;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
          end
          StSymbol: begin
            if (sched.s_axis_in_tvalid) begin
              tdata_q   <= sched.s_axis_in_tdata;
              tvalid_q  <= 1'b1;
              tlast_q   <= (cnt_q == FftLast);
              out_idx_q <= idx_q;
              if (cnt_q == FftLast) begin
                cnt_q <= '0;
                idx_q <= idx_q + 1'b1;
                if (idx_q + 1'b1 == NumSym) begin
                  state_q <= StIdle;
                end else if (CP_LEN == 0) begin
                  state_q <= StSymbol;
                end else begin
                  state_q <= StCp;
                end
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
          end
          StCp: begin
            if (sched.s_axis_in_tvalid) begin
              if (cnt_q == CpLast) begin
                state_q <= StSymbol;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign sched.m_axis_fft_tdata  = tdata_q;
  assign sched.m_axis_fft_tvalid = tvalid_q;
  assign sched.m_axis_fft_tlast  = tlast_q;
  assign sched.symbol_idx_o      = out_idx_q;
  assign sched.busy_o            = (state_q != StIdle);
  assign sched.peak_ignored_o    = ignored_q;
endmodule

// File: tb/tb_fft_symbol_scheduler.sv
// Drives a default scheduler and a CP_LEN=0 / NUM_SYMBOLS=2 scheduler with the same stream
// and scores both against a positional model of the symbol schedule.
module tb_fft_symbol_scheduler;
  localparam int FS = 279;
  localparam int FL = 256;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fft_symbol_scheduler_if #(.IN_DW(32), .NUM_SYMBOLS(3)) ia ();
  fft_symbol_scheduler_if #(.IN_DW(32), .NUM_SYMBOLS(2)) ib ();

  fft_symbol_scheduler #(
    .IN_DW(32), .FFT_LEN(FL), .CP_LEN(18), .FIRST_SKIP(FS), .NUM_SYMBOLS(3)
  ) dut_a (
    .clk_i(clk), .reset_ni(reset_n), .sched(ia)
  );

  fft_symbol_scheduler #(
    .IN_DW(32), .FFT_LEN(FL), .CP_LEN(0), .FIRST_SKIP(FS), .NUM_SYMBOLS(2)
  ) dut_b (
    .clk_i(clk), .reset_ni(reset_n), .sched(ib)
  );

  int checks = 0;
  int errors = 0;

  // Model state per DUT: active flag and count of valid samples since the accepted peak.
  int          cpl[2]  = '{18, 0};
  int          nsym[2] = '{3, 2};
  bit          act[2];
  int          k[2];
  logic        e_tv[2], e_tl[2], e_ign[2], e_busy[2];
  logic [31:0] e_data[2];
  logic [7:0]  e_idx[2];

  // Per-test tallies of observed behaviour.
  int    mism;
  string first_msg;
  int    fwd[2], lasts[2], ign_seen[2];

  function automatic void model_reset();
    for (int n = 0; n < 2; n++) begin
      act[n] = 1'b0; k[n] = 0; e_data[n] = '0; e_idx[n] = '0;
      e_tv[n] = 1'b0; e_tl[n] = 1'b0; e_ign[n] = 1'b0; e_busy[n] = 1'b0;
    end
  endfunction

  function automatic void model(int n, logic v, logic pk, logic ab, logic [31:0] d);
    int p, period, s, r;
    e_tv[n] = 1'b0; e_tl[n] = 1'b0; e_ign[n] = 1'b0;
    if (ab) begin
      act[n] = 1'b0;
    end else if (pk && !act[n]) begin
      act[n] = 1'b1; k[n] = 0;
    end else begin
      if (pk) e_ign[n] = 1'b1;
      if (act[n] && v) begin
        p = k[n] - FS;
        period = FL + cpl[n];
        if (p >= 0) begin
          s = p / period;
          r = p % period;
          if (r < FL) begin
            e_tv[n] = 1'b1; e_tl[n] = (r == FL - 1); e_idx[n] = 8'(s); e_data[n] = d;
            if (s == nsym[n] - 1 && r == FL - 1) act[n] = 1'b0;
          end
        end
        k[n]++;
      end
    end
    e_busy[n] = act[n];
  endfunction

  function automatic void clear_tallies();
    mism = 0; first_msg = "";
    for (int n = 0; n < 2; n++) begin fwd[n] = 0; lasts[n] = 0; ign_seen[n] = 0; end
  endfunction

  // One clock of stimulus on both DUTs; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic [31:0] d, input logic v, input logic pk, input logic ab);
    logic        o_tv[2], o_tl[2], o_ign[2], o_busy[2];
    logic [31:0] o_data[2];
    logic [7:0]  o_idx[2];
    bit          bad;
    ia.s_axis_in_tdata = d; ia.s_axis_in_tvalid = v; ia.peak_detected_i = pk; ia.abort_i = ab;
    ib.s_axis_in_tdata = d; ib.s_axis_in_tvalid = v; ib.peak_detected_i = pk; ib.abort_i = ab;
    @(posedge clk);
    for (int n = 0; n < 2; n++) model(n, v, pk, ab, d);
    #1;
    o_tv[0] = ia.m_axis_fft_tvalid; o_tl[0] = ia.m_axis_fft_tlast; o_data[0] = ia.m_axis_fft_tdata;
    o_idx[0] = 8'(ia.symbol_idx_o); o_busy[0] = ia.busy_o; o_ign[0] = ia.peak_ignored_o;
    o_tv[1] = ib.m_axis_fft_tvalid; o_tl[1] = ib.m_axis_fft_tlast; o_data[1] = ib.m_axis_fft_tdata;
    o_idx[1] = 8'(ib.symbol_idx_o); o_busy[1] = ib.busy_o; o_ign[1] = ib.peak_ignored_o;
    for (int n = 0; n < 2; n++) begin
      if (o_tv[n] === 1'b1) fwd[n]++;
      if (o_tv[n] === 1'b1 && o_tl[n] === 1'b1) lasts[n]++;
      if (o_ign[n] === 1'b1) ign_seen[n]++;
      bad = (o_tv[n] !== e_tv[n]) || (o_tl[n] !== e_tl[n]) || (o_data[n] !== e_data[n]) ||
            (o_busy[n] !== e_busy[n]) || (o_ign[n] !== e_ign[n]) ||
            (e_tv[n] && (o_idx[n] !== e_idx[n]));
      if (bad) begin
        if (mism == 0)
          first_msg = $sformatf(
            "dut%0d @%0t got/exp tv=%b/%b tl=%b/%b data=%h/%h idx=%0d/%0d busy=%b/%b ign=%b/%b",
            n, $time, o_tv[n], e_tv[n], o_tl[n], e_tl[n], o_data[n], e_data[n], o_idx[n],
            e_idx[n], o_busy[n], e_busy[n], o_ign[n], e_ign[n]);
        mism++;
      end
    end
  endtask

  task automatic test_reset();
    ia.s_axis_in_tdata = '0; ia.s_axis_in_tvalid = 0; ia.peak_detected_i = 0; ia.abort_i = 0;
    ib.s_axis_in_tdata = '0; ib.s_axis_in_tvalid = 0; ib.peak_detected_i = 0; ib.abort_i = 0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ia.m_axis_fft_tvalid, ia.m_axis_fft_tlast, ia.busy_o, ia.peak_ignored_o} !== 4'b0 ||
        ia.m_axis_fft_tdata !== '0 || ia.symbol_idx_o !== '0) begin
      errors++;
      $display("FAIL reset_state_a: tv=%b tl=%b busy=%b ign=%b data=%h idx=%0d, required all 0",
               ia.m_axis_fft_tvalid, ia.m_axis_fft_tlast, ia.busy_o, ia.peak_ignored_o,
               ia.m_axis_fft_tdata, ia.symbol_idx_o);
    end
    checks++;
    if ({ib.m_axis_fft_tvalid, ib.m_axis_fft_tlast, ib.busy_o, ib.peak_ignored_o} !== 4'b0 ||
        ib.m_axis_fft_tdata !== '0 || ib.symbol_idx_o !== '0) begin
      errors++;
      $display("FAIL reset_state_b: tv=%b tl=%b busy=%b ign=%b data=%h, required all 0",
               ib.m_axis_fft_tvalid, ib.m_axis_fft_tlast, ib.busy_o, ib.peak_ignored_o,
               ib.m_axis_fft_tdata);
    end
    reset_n = 1'b1;
    model_reset();
    clear_tallies();
    repeat (30) step($urandom, 1'b1, 1'b0, 1'b0);
    checks++;
    if (mism !== 0) begin
      errors++;
      $display("FAIL idle_after_reset: mismatched cycles %0d, required 0; first %s", mism, first_msg);
    end
  endtask

  task automatic test_continuous();
    logic [31:0] r = 0;
    clear_tallies();
    step(32'hdead_beef, 1'b1, 1'b1, 1'b0);
    repeat (1200) begin step(r, 1'b1, 1'b0, 1'b0); r++; end
    checks++;
    if (mism !== 0) begin
      errors++;
      $display("FAIL continuous: mismatched cycles %0d, required 0; first %s", mism, first_msg);
    end
    checks++;
    if (fwd[0] !== 768 || lasts[0] !== 3) begin
      errors++;
      $display("FAIL continuous_count_a: fwd %0d tlast %0d, required 768 and 3", fwd[0], lasts[0]);
    end
    checks++;
    if (fwd[1] !== 512 || lasts[1] !== 2) begin
      errors++;
      $display("FAIL cp0_count_b: fwd %0d tlast %0d, required 512 and 2", fwd[1], lasts[1]);
    end
    checks++;
    if (ia.busy_o !== 1'b0 || ib.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL busy_end: busy a=%b b=%b, required 0 0", ia.busy_o, ib.busy_o);
    end
  endtask

  task automatic test_toggle();
    logic [31:0] r = 0;
    clear_tallies();
    step(32'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2400; i++) begin
      if (i % 2 == 0) begin step(r, 1'b1, 1'b0, 1'b0); r++; end
      else step($urandom, 1'b0, 1'b0, 1'b0);
    end
    checks++;
    if (mism !== 0) begin
      errors++;
      $display("FAIL toggle: mismatched cycles %0d, required 0; first %s", mism, first_msg);
    end
    checks++;
    if (fwd[0] !== 768 || fwd[1] !== 512) begin
      errors++;
      $display("FAIL toggle_count: fwd a=%0d b=%0d, required 768 512", fwd[0], fwd[1]);
    end
  endtask

  task automatic test_peak_ignored();
    clear_tallies();
    step($urandom, 1'b1, 1'b1, 1'b0);
    repeat (FS + 100) step($urandom, 1'b1, 1'b0, 1'b0);
    step($urandom, 1'b1, 1'b1, 1'b0);
    repeat (1200) step($urandom, 1'b1, 1'b0, 1'b0);
    checks++;
    if (mism !== 0) begin
      errors++;
      $display("FAIL peak_ignored: mismatched cycles %0d, required 0; first %s", mism, first_msg);
    end
    checks++;
    if (ign_seen[0] !== 1 || ign_seen[1] !== 1) begin
      errors++;
      $display("FAIL ignored_pulses: a=%0d b=%0d, required 1 1", ign_seen[0], ign_seen[1]);
    end
    checks++;
    if (fwd[0] !== 768 || fwd[1] !== 512) begin
      errors++;
      $display("FAIL ignored_count: fwd a=%0d b=%0d, required 768 512", fwd[0], fwd[1]);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r = 32'h100;
    clear_tallies();
    step(r, 1'b1, 1'b1, 1'b0);
    repeat (FS + FL + 18 + 51) begin step(r, 1'b1, 1'b0, 1'b0); r++; end
    ia.s_axis_in_tvalid = 1'b0; ib.s_axis_in_tvalid = 1'b0;
    #6;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({ia.m_axis_fft_tvalid, ia.m_axis_fft_tlast, ia.busy_o} !== 3'b0 ||
        ia.m_axis_fft_tdata !== '0 || ia.symbol_idx_o !== '0) begin
      errors++;
      $display("FAIL midreset_a: tv=%b tl=%b busy=%b data=%h idx=%0d, required all 0",
               ia.m_axis_fft_tvalid, ia.m_axis_fft_tlast, ia.busy_o, ia.m_axis_fft_tdata,
               ia.symbol_idx_o);
    end
    checks++;
    if ({ib.m_axis_fft_tvalid, ib.busy_o} !== 2'b0 || ib.m_axis_fft_tdata !== '0) begin
      errors++;
      $display("FAIL midreset_b: tv=%b busy=%b data=%h, required all 0",
               ib.m_axis_fft_tvalid, ib.busy_o, ib.m_axis_fft_tdata);
    end
    checks++;
    if (mism !== 0 || fwd[0] !== FL + 51) begin
      errors++;
      $display("FAIL before_midreset: mism %0d fwd %0d, required 0 and %0d; first %s",
               mism, fwd[0], FL + 51, first_msg);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    clear_tallies();
    step($urandom, 1'b1, 1'b1, 1'b0);
    repeat (1200) begin step(r, 1'b1, 1'b0, 1'b0); r++; end
    checks++;
    if (mism !== 0 || fwd[0] !== 768 || fwd[1] !== 512) begin
      errors++;
      $display("FAIL restart: mism %0d fwd a=%0d b=%0d, required 0 768 512; first %s",
               mism, fwd[0], fwd[1], first_msg);
    end
  endtask

  task automatic test_abort();
    int fwd_before;
    clear_tallies();
    step($urandom, 1'b1, 1'b1, 1'b0);
    repeat (FS + FL + 5) step($urandom, 1'b1, 1'b0, 1'b0);
    fwd_before = fwd[0];
    step($urandom, 1'b1, 1'b1, 1'b1);
    repeat (400) step($urandom, 1'b1, 1'b0, 1'b0);
    checks++;
    if (mism !== 0) begin
      errors++;
      $display("FAIL abort: mismatched cycles %0d, required 0; first %s", mism, first_msg);
    end
    checks++;
    if (ign_seen[0] !== 0 || fwd[0] !== fwd_before || fwd_before !== FL) begin
      errors++;
      $display("FAIL abort_in_cp: ignored %0d fwd %0d->%0d, required 0 and %0d->%0d",
               ign_seen[0], fwd_before, fwd[0], FL, FL);
    end
    checks++;
    if (ia.busy_o !== 1'b0 || ib.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy: busy a=%b b=%b, required 0 0", ia.busy_o, ib.busy_o);
    end
  endtask

  task automatic test_random();
    logic v, pk, ab;
    clear_tallies();
    step($urandom, 1'b1, 1'b1, 1'b0);
    repeat (4000) begin
      v  = ($urandom_range(0, 3) != 0);
      pk = ($urandom_range(0, 399) == 0);
      ab = ($urandom_range(0, 1499) == 0);
      step($urandom, v, pk, ab);
    end
    checks++;
    if (mism !== 0) begin
      errors++;
      $display("FAIL random: mismatched cycles %0d, required 0; first %s", mism, first_msg);
    end
    checks++;
    if (fwd[0] === 0) begin
      errors++;
      $display("FAIL random_activity: fwd a=%0d, required nonzero", fwd[0]);
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_toggle();
    test_peak_ignored();
    test_reset_mid();
    test_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
